stream_packetizer: RTL and testbench
====================================

Name: stream_packetizer

Overview:
Parametrised successor to the fixed 32-bit S2MM packetizer. Forwards an upstream AXI-Stream of samples to the AXI DMA S2MM port and asserts TLAST on beat LENGTH of every packet. LENGTH is configurable over AXI4-Lite and takes effect only at packet boundaries. Adds one-shot mode, a packet counter and a registered skid-buffered output; sits between the ADC manager and the AXI DMA.

Parameters:
DATA_WIDTH, 32, stream data width in bits (multiple of 8)
COUNT_WIDTH, 32, width of the beat counter, LENGTH and PKTCNT (≤32)

Ports:
aclk  in  1  clock
aresetn  in  1  reset, asynchronous, active-low
s_axis_tdata  in  DATA_WIDTH  upstream sample data
s_axis_tvalid  in  1  upstream valid
s_axis_tready  out  1  upstream ready
m_axis_tdata  out  DATA_WIDTH  S2MM data
m_axis_tvalid  out  1  S2MM valid
m_axis_tready  in  1  S2MM ready
m_axis_tlast  out  1  last beat of packet
last  out  1  one-cycle pulse on the accepted TLAST beat (m_axis_tvalid & m_axis_tready & m_axis_tlast)
s_axi_lite_*  mixed  32/3/4/2  standard AXI4-Lite subordinate: awaddr, awprot, awvalid, awready, wdata, wstrb, wvalid, wready, bresp, bvalid, bready, araddr, arprot, arvalid, arready, rdata, rresp, rvalid, rready

Behaviour:
- Reset: every output is 0, including all s_axi_lite ready/valid signals. CTRL=0, LENGTH=0, PKTCNT=0, DROPPED=0, beat counter=0, skid buffer empty.
- Register map, decoded on addr[4:2], other address bits ignored:
  - 0x00 CTRL RW: bit0 ENABLE, bit1 ONESHOT, bit2 CLEAR. CLEAR is write-1, self-clearing, reads 0, and zeroes PKTCNT and DROPPED.
  - 0x04 LENGTH RW: beats per packet.
  - 0x08 STATUS RO: current beat count.
  - 0x0C PKTCNT RO: completed packets, wraps at 2^COUNT_WIDTH.
  - 0x10 DROPPED RO: only with the optional feature, otherwise unmapped.
- AXI4-Lite writes:
  - AW and W are accepted independently; awready and wready are deasserted once their channel has been captured.
  - BVALID is raised the cycle after both are held. The next AW/W is accepted after the B handshake.
  - wstrb is honoured per byte.
  - RO or unmapped address gives BRESP=2'b10 with no state change; otherwise BRESP=2'b00.
- AXI4-Lite reads: one outstanding read. rdata is registered and RVALID is raised one cycle after the AR handshake. Unmapped address gives RDATA=0, RRESP=2'b10.
- Shadow registers:
  - length_act and en_act are loaded from LENGTH and CTRL.ENABLE whenever the beat counter is 0.
  - A mid-packet change to LENGTH or ENABLE never alters the current packet; it always completes.
- Gating: the datapath is active iff en_act=1 and length_act≠0. When inactive, s_axis_tready=0 and nothing is forwarded (see Optional Feature).
- Input acceptance: s_axis_tready = active & skid buffer not full. The skid buffer is 2 entries, output registered, so the upstream sees no combinational path from m_axis_tready.
- Latency: a beat accepted in cycle n is presented on m_axis with tvalid=1 in cycle n+1 when the buffer was empty. A full-throughput sequence of one beat per cycle is sustained while m_axis_tready=1.
- TLAST: the beat counter increments on every input handshake. The beat that brings count to length_act is tagged tlast=1 and stored with the data; the counter then returns to 0 in the same cycle.
- PKTCNT increments on each accepted output TLAST beat.
- LENGTH=1 means every beat carries tlast.
- Counter wrap: LENGTH=2^COUNT_WIDTH-1 must work without overflow.
- One-shot: if ONESHOT=1, hardware clears CTRL.ENABLE on the input handshake of the TLAST beat. That clear takes priority over a simultaneous AXI write of ENABLE=1 in the same cycle.
- The output is never dropped or modified once buffered: tvalid stays high with stable data and tlast until the handshake.

Optional Feature:
STREAM_PACKETIZER_DRAIN_EN
- Defined: when inactive, s_axis_tready=1 and every upstream beat is discarded. Each discarded beat increments DROPPED (32-bit, saturating at 0xFFFFFFFF). DROPPED is readable at 0x10 and cleared by CTRL.CLEAR.
- Not defined: inactive means s_axis_tready=0, address 0x10 is unmapped (SLVERR), and no DROPPED logic is built.

Test Plan:
- LENGTH=4, ENABLE=1, continuous input 0..11, m_axis_tready=1 → three packets; tlast on data 3, 7, 11; last pulses 3 times; PKTCNT=3; first m_axis_tvalid one cycle after the first input handshake.
- LENGTH=3, random m_axis_tready stalls at ~50% → output order and data identical to input, tdata and tlast stable while stalled, s_axis_tready low only when the buffer is full.
- LENGTH=5, ENABLE=1, write LENGTH=2 after beat 2 → current packet ends at beat 5, following packets are 2 beats each; STATUS read mid-packet returns 2.
- ONESHOT=1, ENABLE=1, LENGTH=3 → exactly 3 beats with tlast on the third, then CTRL reads 0x2 and s_axis_tready=0; write 0x08 → BRESP=2'b10.
- ENABLE=0 with input valid → no output; s_axis_tready=0, or with STREAM_PACKETIZER_DRAIN_EN tready=1 and DROPPED=10 after 10 beats; CLEAR → DROPPED=0, PKTCNT=0.
- aresetn asserted mid-packet (beat 2 of 4) → all outputs 0 immediately, CTRL=0; after release and reconfiguration, the first packet tlast is on beat 4.

Source files
------------

// File: rtl/stream_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : stream_packetizer
//  Brief    : AXI-Stream to AXI DMA S2MM packetizer. Tags TLAST on every
//             LENGTH-th beat and forwards through a 2-entry registered skid
//             buffer. AXI4-Lite registers: CTRL, LENGTH, STATUS, PKTCNT.
//             Optional macro STREAM_PACKETIZER_DRAIN_EN: while inactive the
//             upstream is drained and discarded beats are counted in DROPPED.
//  Revision : 1.0 - initial parametrised release
// ============================================================================
module stream_packetizer #(
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  last,
  input  logic [31:0]           s_axi_lite_awaddr,
  input  logic [2:0]            s_axi_lite_awprot,
  input  logic                  s_axi_lite_awvalid,
  output logic                  s_axi_lite_awready,
  input  logic [31:0]           s_axi_lite_wdata,
  input  logic [3:0]            s_axi_lite_wstrb,
  input  logic                  s_axi_lite_wvalid,
  output logic                  s_axi_lite_wready,
  output logic [1:0]            s_axi_lite_bresp,
  output logic                  s_axi_lite_bvalid,
  input  logic                  s_axi_lite_bready,
  input  logic [31:0]           s_axi_lite_araddr,
  input  logic [2:0]            s_axi_lite_arprot,
  input  logic                  s_axi_lite_arvalid,
  output logic                  s_axi_lite_arready,
  output logic [31:0]           s_axi_lite_rdata,
  output logic [1:0]            s_axi_lite_rresp,
  output logic                  s_axi_lite_rvalid,
  input  logic                  s_axi_lite_rready
);

  localparam logic [1:0] c_RESP_OKAY   = 2'b00;
  localparam logic [1:0] c_RESP_SLVERR = 2'b10;
  localparam logic [2:0] c_ADDR_CTRL   = 3'd0;
  localparam logic [2:0] c_ADDR_LENGTH = 3'd1;
  localparam logic [2:0] c_ADDR_STATUS = 3'd2;
  localparam logic [2:0] c_ADDR_PKTCNT = 3'd3;
  localparam logic [2:0] c_ADDR_DROP   = 3'd4;

  logic                   r_up;
  logic                   r_aw_held, r_w_held, r_bvalid, r_rvalid;
  logic [2:0]             r_aw_idx;
  logic [31:0]            r_wdata, r_rdata;
  logic [3:0]             r_wstrb;
  logic [1:0]             r_bresp, r_rresp;
  logic                   r_enable, r_oneshot, r_en_act;
  logic [COUNT_WIDTH-1:0] r_length, r_len_act, r_beat, r_pktcnt;
  logic                   r_v0, r_v1, r_l0, r_l1;
  logic [DATA_WIDTH-1:0]  r_d0, r_d1;

  logic                   w_en_eff, w_active, w_is_last, w_push, w_pop, w_idle_ready;
  logic [COUNT_WIDTH-1:0] w_len_eff, w_beat_inc;
  logic                   w_do_write, w_wr_ok, w_wr_ctrl, w_wr_len, w_clear, w_out_last;
  logic [31:0]            w_len32, w_rd_data;
  logic [1:0]             w_rd_resp;
  logic                   w_unused;

  // Shadow values: live registers at a packet boundary, latched copies mid-packet
  assign w_en_eff   = (r_beat == '0) ? r_enable : r_en_act;
  assign w_len_eff  = (r_beat == '0) ? r_length : r_len_act;
  assign w_active   = w_en_eff & (w_len_eff != '0);
  assign w_beat_inc = r_beat + 1'b1;
  assign w_is_last  = (w_beat_inc == w_len_eff);

`ifdef STREAM_PACKETIZER_DRAIN_EN
  assign w_idle_ready = 1'b1;
`else
  assign w_idle_ready = 1'b0;
`endif

  // Ready depends only on registers, so m_axis_tready never reaches upstream
  assign s_axis_tready = r_up & (w_active ? ~r_v1 : w_idle_ready);
  assign w_push        = s_axis_tvalid & s_axis_tready & w_active;
  assign w_pop         = r_v0 & m_axis_tready;
  assign m_axis_tvalid = r_v0;
  assign m_axis_tdata  = r_d0;
  assign m_axis_tlast  = r_l0;
  assign w_out_last    = r_v0 & m_axis_tready & r_l0;
  assign last          = w_out_last;

  assign s_axi_lite_awready = r_up & ~r_aw_held & ~r_bvalid;
  assign s_axi_lite_wready  = r_up & ~r_w_held & ~r_bvalid;
  assign s_axi_lite_bvalid  = r_bvalid;
  assign s_axi_lite_bresp   = r_bresp;
  assign s_axi_lite_arready = r_up & ~r_rvalid;
  assign s_axi_lite_rvalid  = r_rvalid;
  assign s_axi_lite_rdata   = r_rdata;
  assign s_axi_lite_rresp   = r_rresp;

  assign w_do_write = r_aw_held & r_w_held & ~r_bvalid;
  assign w_wr_ok    = (r_aw_idx == c_ADDR_CTRL) | (r_aw_idx == c_ADDR_LENGTH);
  assign w_wr_ctrl  = w_do_write & (r_aw_idx == c_ADDR_CTRL);
  assign w_wr_len   = w_do_write & (r_aw_idx == c_ADDR_LENGTH);
  assign w_clear    = w_wr_ctrl & r_wstrb[0] & r_wdata[2];

  assign w_unused = &{1'b0, s_axi_lite_awaddr[31:5], s_axi_lite_awaddr[1:0],
                      s_axi_lite_araddr[31:5], s_axi_lite_araddr[1:0],
                      s_axi_lite_awprot, s_axi_lite_arprot, w_len32};

  // LENGTH write value with per-byte strobes merged over the current value
  always_comb begin
    w_len32 = 32'h0;
    w_len32[COUNT_WIDTH-1:0] = r_length;
    for (int i = 0; i < 4; i++) begin
      if (r_wstrb[i]) w_len32[8*i +: 8] = r_wdata[8*i +: 8];
    end
  end

  // Bus interface comes alive one cycle after reset release
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_up <= 1'b0;
    else          r_up <= 1'b1;
  end

  // AXI4-Lite write: capture AW and W independently, respond once both held
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_aw_held <= 1'b0;
      r_w_held  <= 1'b0;
      r_aw_idx  <= 3'd0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_bvalid  <= 1'b0;
      r_bresp   <= c_RESP_OKAY;
    end else begin
      if (s_axi_lite_awvalid & s_axi_lite_awready) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= s_axi_lite_awaddr[4:2];
      end
      if (s_axi_lite_wvalid & s_axi_lite_wready) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axi_lite_wdata;
        r_wstrb  <= s_axi_lite_wstrb;
      end
      if (w_do_write) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_ok ? c_RESP_OKAY : c_RESP_SLVERR;
      end else if (r_bvalid & s_axi_lite_bready) begin
        r_bvalid <= 1'b0;
      end
    end
  end

  // CTRL and LENGTH; one-shot clear of ENABLE overrides a same-cycle write
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_enable  <= 1'b0;
      r_oneshot <= 1'b0;
      r_length  <= '0;
    end else begin
      if (w_wr_ctrl & r_wstrb[0]) begin
        r_enable  <= r_wdata[0];
        r_oneshot <= r_wdata[1];
      end
      if (w_push & w_is_last & r_oneshot) r_enable <= 1'b0;
      if (w_wr_len) r_length <= w_len32[COUNT_WIDTH-1:0];
    end
  end

  // Read data mux
  always_comb begin
    w_rd_data = 32'h0;
    w_rd_resp = c_RESP_OKAY;
    case (s_axi_lite_araddr[4:2])
      c_ADDR_CTRL:   w_rd_data[1:0] = {r_oneshot, r_enable};
      c_ADDR_LENGTH: w_rd_data[COUNT_WIDTH-1:0] = r_length;
      c_ADDR_STATUS: w_rd_data[COUNT_WIDTH-1:0] = r_beat;
      c_ADDR_PKTCNT: w_rd_data[COUNT_WIDTH-1:0] = r_pktcnt;
`ifdef STREAM_PACKETIZER_DRAIN_EN
      c_ADDR_DROP:   w_rd_data = r_dropped;
`endif
      default:       w_rd_resp = c_RESP_SLVERR;
    endcase
  end

  // AXI4-Lite read: single outstanding, registered response
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_rvalid <= 1'b0;
      r_rdata  <= 32'h0;
      r_rresp  <= c_RESP_OKAY;
    end else if (s_axi_lite_arvalid & s_axi_lite_arready) begin
      r_rvalid <= 1'b1;
      r_rdata  <= w_rd_data;
      r_rresp  <= w_rd_resp;
    end else if (r_rvalid & s_axi_lite_rready) begin
      r_rvalid <= 1'b0;
    end
  end

  // Beat counter and packet-boundary shadow registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_beat    <= '0;
      r_len_act <= '0;
      r_en_act  <= 1'b0;
    end else begin
      if (r_beat == '0) begin
        r_len_act <= r_length;
        r_en_act  <= r_enable;
      end
      if (w_push) r_beat <= w_is_last ? '0 : w_beat_inc;
    end
  end

  // Completed-packet counter, counted at the output handshake
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)        r_pktcnt <= '0;
    else if (w_clear)    r_pktcnt <= '0;
    else if (w_out_last) r_pktcnt <= r_pktcnt + 1'b1;
  end

`ifdef STREAM_PACKETIZER_DRAIN_EN
  logic [31:0] r_dropped;
  logic        w_drop;
  assign w_drop = s_axis_tvalid & s_axis_tready & ~w_active;

  // Saturating count of beats discarded while inactive
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                            r_dropped <= 32'h0;
    else if (w_clear)                        r_dropped <= 32'h0;
    else if (w_drop && r_dropped != 32'hFFFF_FFFF) r_dropped <= r_dropped + 1'b1;
  end
`endif

  // Two-entry skid buffer; slot 0 drives the output, slot 1 absorbs a stall
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_d0 <= '0;
      r_d1 <= '0;
      r_l0 <= 1'b0;
      r_l1 <= 1'b0;
    end else if (w_pop) begin
      if (r_v1) begin
        r_d0 <= r_d1;
        r_l0 <= r_l1;
        r_v1 <= 1'b0;
      end else if (w_push) begin
        r_d0 <= s_axis_tdata;
        r_l0 <= w_is_last;
      end else begin
        r_v0 <= 1'b0;
      end
    end else if (w_push) begin
      if (!r_v0) begin
        r_v0 <= 1'b1;
        r_d0 <= s_axis_tdata;
        r_l0 <= w_is_last;
      end else begin
        r_v1 <= 1'b1;
        r_d1 <= s_axis_tdata;
        r_l1 <= w_is_last;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stream_packetizer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stream_packetizer
//  Brief    : Self-checking bench for stream_packetizer: register vector
//             table, directed packet sequences and randomized stalls checked
//             against a packet-length model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stream_packetizer;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] s_axis_tdata = '0;
  logic        s_axis_tvalid = 1'b0;
  logic        s_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b1;
  logic        m_axis_tlast;
  logic        last;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [2:0]  awprot = '0, arprot = '0;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;

  always #5 aclk = ~aclk;

  stream_packetizer #(.DATA_WIDTH(32), .COUNT_WIDTH(32)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .last(last),
    .s_axi_lite_awaddr(awaddr), .s_axi_lite_awprot(awprot), .s_axi_lite_awvalid(awvalid),
    .s_axi_lite_awready(awready), .s_axi_lite_wdata(wdata), .s_axi_lite_wstrb(wstrb),
    .s_axi_lite_wvalid(wvalid), .s_axi_lite_wready(wready), .s_axi_lite_bresp(bresp),
    .s_axi_lite_bvalid(bvalid), .s_axi_lite_bready(bready), .s_axi_lite_araddr(araddr),
    .s_axi_lite_arprot(arprot), .s_axi_lite_arvalid(arvalid), .s_axi_lite_arready(arready),
    .s_axi_lite_rdata(rdata), .s_axi_lite_rresp(rresp), .s_axi_lite_rvalid(rvalid),
    .s_axi_lite_rready(rready)
  );

`ifdef STREAM_PACKETIZER_DRAIN_EN
  localparam logic [1:0] DROP_RESP = 2'b00;
`else
  localparam logic [1:0] DROP_RESP = 2'b10;
`endif

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Stream driver / monitor state
  int          feed_left = 0;
  logic [31:0] feed_data = '0;
  bit          rand_ready = 0, rand_valid = 0, chk_full = 0, chk_stable = 0;
  logic [31:0] in_d[$], out_d[$];
  bit          out_l[$];
  int          exp_lens[$];
  int          last_cnt = 0, cyc = 0, first_in = -1, first_v = -1;
  bit          in_hs = 0;
  logic        pv = 0, pr = 0, pl = 0;
  logic [31:0] pd = '0;

  // Drives the stream on the falling edge, samples 2 time units later
  initial forever begin
    @(negedge aclk);
    cyc++;
    if (in_hs) begin
      feed_data++;
      if (feed_left > 0) feed_left--;
    end
    if (!(s_axis_tvalid && !in_hs))
      s_axis_tvalid = (feed_left > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
    if (feed_left == 0) s_axis_tvalid = 1'b0;
    s_axis_tdata  = feed_data;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    #2;
    if (chk_stable && pv && !pr)
      chk("hold_stable", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, pl, pd});
    if (chk_full && aresetn)
      chk("ready_iff_not_full", s_axis_tready, (in_d.size() - out_d.size()) < 2);
    in_hs = s_axis_tvalid && s_axis_tready;
    if (in_hs) begin
      in_d.push_back(s_axis_tdata);
      if (first_in < 0) first_in = cyc;
    end
    if (m_axis_tvalid && first_in >= 0 && first_v < 0) first_v = cyc;
    if (m_axis_tvalid && m_axis_tready) begin
      out_d.push_back(m_axis_tdata);
      out_l.push_back(m_axis_tlast);
    end
    if (last) last_cnt++;
    pv = m_axis_tvalid; pr = m_axis_tready; pd = m_axis_tdata; pl = m_axis_tlast;
  end

  task automatic axi_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [1:0] resp);
    bit ah, wh, got;
    got = 0; resp = 2'bxx;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      ah = awvalid && awready;
      wh = wvalid && wready;
      if (bvalid && bready) begin resp = bresp; got = 1; end
      @(negedge aclk);
      if (ah) awvalid = 0;
      if (wh) wvalid = 0;
    end
    awvalid = 0; wvalid = 0; bready = 0;
    if (!got) begin checks++; errors++; $display("FAIL axi_wr_timeout addr=%0h", a); end
  endtask

  task automatic axi_rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit ah, got;
    got = 0; d = 'x; resp = 2'bxx;
    araddr = a; arvalid = 1; rready = 1;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      ah = arvalid && arready;
      if (rvalid && rready) begin d = rdata; resp = rresp; got = 1; end
      @(negedge aclk);
      if (ah) arvalid = 0;
    end
    arvalid = 0; rready = 0;
    if (!got) begin checks++; errors++; $display("FAIL axi_rd_timeout addr=%0h", a); end
  endtask

  task automatic wr_chk(input string nm, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic [1:0] exp_r);
    logic [1:0] r;
    axi_wr(a, d, s, r);
    chk(nm, r, exp_r);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wr_chk($sformatf("wr_%0h", a), a, d, 4'hF, 2'b00);
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a, input logic [31:0] exp_d,
                        input logic [1:0] exp_r);
    logic [31:0] d;
    logic [1:0]  r;
    axi_rd(a, d, r);
    chk(nm, {r, d}, {exp_r, exp_d});
  endtask

  task automatic wait_in(input int n);
    for (int i = 0; i < 2000 && in_d.size() < n; i++) @(negedge aclk);
    chk("wait_in", in_d.size() >= n, 1);
  endtask

  task automatic wait_out(input int n);
    for (int i = 0; i < 4000 && out_d.size() < n; i++) @(negedge aclk);
    chk("wait_out", out_d.size() >= n, 1);
  endtask

  task automatic clr();
    in_d.delete(); out_d.delete(); out_l.delete();
    last_cnt = 0; first_in = -1; first_v = -1;
  endtask

  // Model: output equals accepted input in order; tlast closes each packet of
  // the listed lengths, the final length repeating
  task automatic check_stream(input string nm);
    int  pos, pk;
    bit  exp_l;
    pos = 0; pk = 0;
    chk({nm, "_beats"}, out_d.size(), in_d.size());
    for (int i = 0; i < out_d.size() && i < in_d.size(); i++) begin
      pos++;
      exp_l = (pos == exp_lens[pk]);
      if (exp_l) begin
        pos = 0;
        if (pk < exp_lens.size() - 1) pk++;
      end
      chk($sformatf("%s_beat%0d", nm, i), {out_l[i], out_d[i]}, {exp_l, in_d[i]});
    end
  endtask

  task automatic chk_reset_outs(input string nm);
    chk({nm, "_ctl"}, {s_axis_tready, m_axis_tvalid, m_axis_tlast, last, awready, wready,
                       bvalid, bresp, arready, rvalid, rresp}, '0);
    chk({nm, "_data"}, {m_axis_tdata, rdata}, '0);
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  vec_t vt[24];

  initial begin
    vt[0]  = '{0, 32'h00, 32'h0,         4'h0, 2'b00, 32'h0};
    vt[1]  = '{0, 32'h04, 32'h0,         4'h0, 2'b00, 32'h0};
    vt[2]  = '{0, 32'h08, 32'h0,         4'h0, 2'b00, 32'h0};
    vt[3]  = '{0, 32'h0C, 32'h0,         4'h0, 2'b00, 32'h0};
    vt[4]  = '{0, 32'h10, 32'h0,         4'h0, DROP_RESP, 32'h0};
    vt[5]  = '{0, 32'h14, 32'h0,         4'h0, 2'b10, 32'h0};
    vt[6]  = '{1, 32'h04, 32'h12345678,  4'h3, 2'b00, 32'h0};
    vt[7]  = '{0, 32'h04, 32'h0,         4'h0, 2'b00, 32'h00005678};
    vt[8]  = '{1, 32'h04, 32'hAB000000,  4'h8, 2'b00, 32'h0};
    vt[9]  = '{0, 32'h04, 32'h0,         4'h0, 2'b00, 32'hAB005678};
    vt[10] = '{1, 32'h08, 32'hFFFFFFFF,  4'hF, 2'b10, 32'h0};
    vt[11] = '{0, 32'h08, 32'h0,         4'h0, 2'b00, 32'h0};
    vt[12] = '{1, 32'h0C, 32'h5,         4'hF, 2'b10, 32'h0};
    vt[13] = '{0, 32'h0C, 32'h0,         4'h0, 2'b00, 32'h0};
    vt[14] = '{1, 32'h00, 32'h6,         4'hF, 2'b00, 32'h0};
    vt[15] = '{0, 32'h00, 32'h0,         4'h0, 2'b00, 32'h2};
    vt[16] = '{1, 32'h00, 32'hFF,        4'h0, 2'b00, 32'h0};
    vt[17] = '{0, 32'h20, 32'h0,         4'h0, 2'b00, 32'h2};
    vt[18] = '{1, 32'h1C, 32'h1,         4'hF, 2'b10, 32'h0};
    vt[19] = '{0, 32'h24, 32'h0,         4'h0, 2'b00, 32'hAB005678};
    vt[20] = '{1, 32'h00, 32'h0,         4'hF, 2'b00, 32'h0};
    vt[21] = '{0, 32'h00, 32'h0,         4'h0, 2'b00, 32'h0};
    vt[22] = '{1, 32'h04, 32'hFFFFFFFF,  4'hF, 2'b00, 32'h0};
    vt[23] = '{0, 32'h04, 32'h0,         4'h0, 2'b00, 32'hFFFFFFFF};

    // Reset state
    repeat (3) @(negedge aclk);
    #1 chk_reset_outs("reset");
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);

    // Register vector table
    for (int i = 0; i < 24; i++) begin
      if (vt[i].is_wr) wr_chk($sformatf("vec%0d_wr", i), vt[i].addr, vt[i].data, vt[i].strb, vt[i].resp);
      else             rd_chk($sformatf("vec%0d_rd", i), vt[i].addr, vt[i].rdata, vt[i].resp);
    end

    // LENGTH=4, continuous 0..11, no back-pressure
    clr();
    wr(32'h04, 4); wr(32'h00, 1);
    feed_data = 0; feed_left = 12;
    wait_out(12);
    repeat (3) @(negedge aclk);
    exp_lens.delete(); exp_lens.push_back(4);
    check_stream("len4");
    chk("len4_last_pulses", last_cnt, 3);
    chk("len4_latency", first_v - first_in, 1);
    rd_chk("len4_pktcnt", 32'h0C, 3, 2'b00);

    // LENGTH=3 with random stalls on both sides
    clr();
    wr(32'h04, 3);
    feed_data = 1000; rand_ready = 1; rand_valid = 1; chk_stable = 1; chk_full = 1;
    feed_left = 30;
    wait_out(30);
    rand_ready = 0; rand_valid = 0;
    repeat (3) @(negedge aclk);
    chk_full = 0; chk_stable = 0;
    exp_lens.delete(); exp_lens.push_back(3);
    check_stream("stall");
    rd_chk("stall_pktcnt", 32'h0C, 13, 2'b00);

    // LENGTH=5, change to 2 after beat 2: current packet still 5
    clr();
    wr(32'h04, 5);
    feed_data = 2000; feed_left = 2;
    wait_in(2);
    repeat (2) @(negedge aclk);
    wr(32'h04, 2);
    rd_chk("status_mid", 32'h08, 2, 2'b00);
    feed_left = 9;
    wait_out(11);
    repeat (3) @(negedge aclk);
    exp_lens.delete(); exp_lens.push_back(5); exp_lens.push_back(2);
    check_stream("relen");
    rd_chk("relen_pktcnt", 32'h0C, 17, 2'b00);

    // One-shot, LENGTH=3
    clr();
    wr(32'h04, 3); wr(32'h00, 3);
    feed_data = 3000; feed_left = 6;
    repeat (30) @(negedge aclk);
    chk("oneshot_out_n", out_d.size(), 3);
    for (int i = 0; i < 3; i++)
      if (i < out_d.size())
        chk($sformatf("oneshot_beat%0d", i), {out_l[i], out_d[i]}, {(i == 2), 32'(3000 + i)});
`ifdef STREAM_PACKETIZER_DRAIN_EN
    chk("oneshot_tready_drain", s_axis_tready, 1);
`else
    chk("oneshot_in_n", in_d.size(), 3);
    chk("oneshot_tready", s_axis_tready, 0);
`endif
    feed_left = 0;
    rd_chk("oneshot_ctrl", 32'h00, 32'h2, 2'b00);
    wr_chk("status_wr_slverr", 32'h08, 32'h1, 4'hF, 2'b10);
    rd_chk("oneshot_pktcnt", 32'h0C, 18, 2'b00);

    // Disabled: no output; CLEAR zeroes counters
    wr(32'h00, 4);
    rd_chk("clear_pktcnt", 32'h0C, 0, 2'b00);
    rd_chk("clear_ctrl", 32'h00, 0, 2'b00);
    clr();
    feed_data = 4000; feed_left = 10;
    repeat (30) @(negedge aclk);
    chk("disabled_no_out", out_d.size(), 0);
    chk("disabled_tvalid", m_axis_tvalid, 0);
`ifdef STREAM_PACKETIZER_DRAIN_EN
    chk("drain_in_n", in_d.size(), 10);
    rd_chk("dropped_10", 32'h10, 10, 2'b00);
    wr(32'h00, 4);
    rd_chk("dropped_clear", 32'h10, 0, 2'b00);
`else
    chk("disabled_in_n", in_d.size(), 0);
    chk("disabled_tready", s_axis_tready, 0);
`endif
    feed_left = 0;
    repeat (2) @(negedge aclk);

    // Reset mid-packet (beat 2 of 4), then reconfigure
    clr();
    wr(32'h04, 4); wr(32'h00, 1);
    feed_data = 5000; feed_left = 2;
    wait_in(2);
    repeat (3) @(negedge aclk);
    aresetn = 1'b0;
    #1 chk_reset_outs("midreset");
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    repeat (2) @(negedge aclk);
    rd_chk("midreset_ctrl", 32'h00, 0, 2'b00);
    rd_chk("midreset_status", 32'h08, 0, 2'b00);
    clr();
    wr(32'h04, 4); wr(32'h00, 1);
    feed_data = 6000; feed_left = 8;
    wait_out(8);
    repeat (3) @(negedge aclk);
    exp_lens.delete(); exp_lens.push_back(4);
    check_stream("postreset");
    chk("postreset_last_pulses", last_cnt, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
